// File: rtl/gpio_exp_pkg.sv
// Shared definitions for the SPI GPIO expander.
// Contents: register offsets within a bank, the ISTAT base address, frame geometry
// and the 7-bit register address type.
package gpio_exp_pkg;

  localparam logic [1:0] OFF_OUT = 2'd0;
  localparam logic [1:0] OFF_DIR = 2'd1;
  localparam logic [1:0] OFF_IN  = 2'd2;
  localparam logic [1:0] OFF_IEN = 2'd3;

  localparam logic [6:0] ISTAT_BASE = 7'h40;

  localparam int FRAME_BITS = 16;
  localparam int CMD_BITS   = 8;

  typedef logic [6:0] reg_addr_t;

endpackage

// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave front end, oversampled on clk.
// Ports:
//   clk, rst          system clock, async active-low reset
//   spi_ss_n/sclk/mosi  raw SPI pad inputs
//   spi_miso, spi_miso_oe  serial read data and pad enable
//   cmd_valid, addr, rw    one-clk pulse after the 8th sclk rise with decoded command
//   wr_valid, wdata        one-clk pulse after the 16th sclk rise with the data byte
//   rdata                  read data, sampled the clk cmd_valid is high
module spi_frame_rx
  import gpio_exp_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_ss_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       cmd_valid,
  output reg_addr_t  addr,
  output logic       rw,
  output logic       wr_valid,
  output logic [7:0] wdata,
  input  logic [7:0] rdata
);

  localparam logic [4:0] CNT_CMD  = 5'(CMD_BITS - 1);
  localparam logic [4:0] CNT_LAST = 5'(FRAME_BITS - 1);
  localparam logic [4:0] CNT_MAX  = 5'(FRAME_BITS);

  logic [SYNC_STAGES-1:0] r_ss_sync, r_sclk_sync, r_mosi_sync;
  logic       r_sclk_d;
  logic [4:0] r_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_miso_sr;
  logic       r_miso;
  logic       w_ss, w_sclk, w_mosi, w_rise, w_fall;

  assign w_ss   = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise = w_sclk & ~r_sclk_d;
  assign w_fall = ~w_sclk & r_sclk_d;

  assign spi_miso    = r_miso;
  assign spi_miso_oe = ~w_ss;

  // ss_n synchroniser resets to idle so the pad enable stays off coming out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ss_sync   <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi_ss_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sclk_d    <= w_sclk;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_miso_sr <= '0;
      r_miso    <= 1'b0;
      cmd_valid <= 1'b0;
      wr_valid  <= 1'b0;
      addr      <= '0;
      rw        <= 1'b0;
      wdata     <= '0;
    end else begin
      cmd_valid <= 1'b0;
      wr_valid  <= 1'b0;
      if (w_ss) begin
        r_cnt     <= '0;
        r_shift   <= '0;
        r_miso_sr <= '0;
        r_miso    <= 1'b0;
      end else begin
        if (w_rise && (r_cnt < CNT_MAX)) begin
          r_cnt   <= r_cnt + 5'd1;
          r_shift <= {r_shift[6:0], w_mosi};
          if (r_cnt == CNT_CMD) begin
            cmd_valid <= 1'b1;
            rw        <= r_shift[6];
            addr      <= {r_shift[5:0], w_mosi};
          end
          if (r_cnt == CNT_LAST) begin
            wr_valid <= 1'b1;
            wdata    <= {r_shift[6:0], w_mosi};
          end
        end
        // Load lands before the first fall after bit 8 since clk >= 4x sclk;
        // zeros shift in behind the byte so extra bits read as 0.
        if (cmd_valid) begin
          r_miso_sr <= rw ? rdata : 8'h00;
        end else if (w_fall) begin
          r_miso    <= r_miso_sr[7];
          r_miso_sr <= {r_miso_sr[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/spi_gpio_expander.sv
// SPI-controlled GPIO expander: NUM_BANKS x 8 pins with direction, input readback
// and masked change interrupt.
// Ports:
//   clk, rst                  system clock, async active-low reset
//   spi_ss_n, spi_sclk, spi_mosi, spi_miso, spi_miso_oe   SPI slave pads
//   gpio_in [W]   pad inputs (async), gpio_out [W] OUT regs, gpio_oe [W] DIR regs
//   irq           registered OR of all ISTAT bits
module spi_gpio_expander
  import gpio_exp_pkg::*;
#(
  parameter int NUM_BANKS   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spi_ss_n,
  input  logic                   spi_sclk,
  input  logic                   spi_mosi,
  output logic                   spi_miso,
  output logic                   spi_miso_oe,
  input  logic [8*NUM_BANKS-1:0] gpio_in,
  output logic [8*NUM_BANKS-1:0] gpio_out,
  output logic [8*NUM_BANKS-1:0] gpio_oe,
  output logic                   irq
);

  localparam int W = 8 * NUM_BANKS;

  logic       w_cmd_valid, w_rw, w_wr_valid, w_wr;
  reg_addr_t  w_addr;
  logic [7:0] w_wdata, w_rdata, w_rd_mux;
  logic [W-1:0] r_out, r_dir, r_ien, r_istat, r_gprev;
  logic [W-1:0] w_gin, w_set, w_w1c;
  logic [W-1:0] r_gsync [SYNC_STAGES];
  logic         r_irq;

  spi_frame_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .spi_ss_n    (spi_ss_n),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .cmd_valid   (w_cmd_valid),
    .addr        (w_addr),
    .rw          (w_rw),
    .wr_valid    (w_wr_valid),
    .wdata       (w_wdata),
    .rdata       (w_rdata)
  );

  assign w_wr     = w_wr_valid & ~w_rw;
  assign w_gin    = r_gsync[SYNC_STAGES-1];
  assign w_set    = (w_gin ^ r_gprev) & r_ien & ~r_dir;
  assign w_rdata  = (w_cmd_valid && w_rw) ? w_rd_mux : 8'h00;
  assign gpio_out = r_out;
  assign gpio_oe  = r_dir;
  assign irq      = r_irq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_gsync[s] <= '0;
      r_gprev <= '0;
    end else begin
      r_gsync[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_gsync[s] <= r_gsync[s-1];
      r_gprev <= w_gin;
    end
  end

  // Read mux and ISTAT clear mask; addr[6:2] == b only matches the lower bank map
  always_comb begin
    w_rd_mux = 8'h00;
    w_w1c    = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (w_addr[6:2] == 5'(b)) begin
        case (w_addr[1:0])
          OFF_OUT: w_rd_mux = r_out[b*8 +: 8];
          OFF_DIR: w_rd_mux = r_dir[b*8 +: 8];
          OFF_IN:  w_rd_mux = w_gin[b*8 +: 8];
          default: w_rd_mux = r_ien[b*8 +: 8];
        endcase
      end
      if (w_addr == ISTAT_BASE + 7'(b)) begin
        w_rd_mux = r_istat[b*8 +: 8];
        if (w_wr) w_w1c[b*8 +: 8] = w_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out   <= '0;
      r_dir   <= '0;
      r_ien   <= '0;
      r_istat <= '0;
      r_irq   <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_wr && (w_addr[6:2] == 5'(b))) begin
          if (w_addr[1:0] == OFF_OUT) r_out[b*8 +: 8] <= w_wdata;
          if (w_addr[1:0] == OFF_DIR) r_dir[b*8 +: 8] <= w_wdata;
          if (w_addr[1:0] == OFF_IEN) r_ien[b*8 +: 8] <= w_wdata;
        end
      end
      // set term applied after the clear so a same-cycle edge is not lost
      r_istat <= (r_istat & ~w_w1c) | w_set;
      r_irq   <= |r_istat;
    end
  end

endmodule

// File: tb/tb_spi_gpio_expander.sv
module tb_spi_gpio_expander;

  localparam int NB   = 2;
  localparam int W    = 8 * NB;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic spi_ss_n = 1'b1, spi_sclk = 1'b0, spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe, irq;
  logic [W-1:0] gpio_in = '0;
  logic [W-1:0] gpio_out, gpio_oe;

  int n_chk = 0;
  int n_err = 0;

  // reference register model
  logic [W-1:0] m_out, m_dir, m_ien, m_ist, m_gin;

  spi_gpio_expander #(.NUM_BANKS(NB), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_ss_n    (spi_ss_n),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .gpio_oe     (gpio_oe),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic void m_reset();
    m_out = '0; m_dir = '0; m_ien = '0; m_ist = '0; m_gin = gpio_in;
  endfunction

  function automatic void m_pins(input logic [W-1:0] nv);
    for (int i = 0; i < W; i++)
      if ((nv[i] != m_gin[i]) && m_ien[i] && !m_dir[i]) m_ist[i] = 1'b1;
    m_gin = nv;
  endfunction

  function automatic void m_write(input int a, input logic [7:0] d);
    if (a < 4 * NB) begin
      case (a % 4)
        0: m_out[(a/4)*8 +: 8] = d;
        1: m_dir[(a/4)*8 +: 8] = d;
        3: m_ien[(a/4)*8 +: 8] = d;
        default: ;
      endcase
    end else if (a >= 64 && a < 64 + NB) begin
      m_ist[(a-64)*8 +: 8] = m_ist[(a-64)*8 +: 8] & ~d;
    end
  endfunction

  function automatic logic [7:0] m_read(input int a);
    if (a < 4 * NB) begin
      case (a % 4)
        0: return m_out[(a/4)*8 +: 8];
        1: return m_dir[(a/4)*8 +: 8];
        2: return m_gin[(a/4)*8 +: 8];
        default: return m_ien[(a/4)*8 +: 8];
      endcase
    end else if (a >= 64 && a < 64 + NB) begin
      return m_ist[(a-64)*8 +: 8];
    end
    return 8'h00;
  endfunction

  task automatic set_gin(input logic [W-1:0] v);
    m_pins(v);
    gpio_in = v;
    wait_clk(6);
  endtask

  // bits sent MSB first from tx[31] down; tog flips gpio_in[8] one clk after the last rise
  task automatic xfer(input logic [31:0] tx, input int nbits, input logic tog,
                      output logic [7:0] rx, output logic [7:0] ext);
    logic m;
    rx = 8'h00; ext = 8'h00;
    spi_ss_n = 1'b0;
    wait_clk(4);
    chk("miso_oe_on", {31'd0, spi_miso_oe}, 32'd1);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[31-i];
      wait_clk(HALF);
      m = spi_miso;
      spi_sclk = 1'b1;
      if (tog && i == nbits - 1) begin
        wait_clk(1);
        gpio_in[8] = ~gpio_in[8];
        wait_clk(HALF - 1);
      end else begin
        wait_clk(HALF);
      end
      spi_sclk = 1'b0;
      if (i >= 8 && i < 16) rx = {rx[6:0], m};
      else if (i >= 16 && i < 24) ext = {ext[6:0], m};
    end
    wait_clk(HALF);
    spi_ss_n = 1'b1;
    wait_clk(6);
    chk("miso_oe_off", {31'd0, spi_miso_oe}, 32'd0);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] rx, ext;
    xfer({1'b0, a, d, 16'h0}, 16, 1'b0, rx, ext);
    m_write(int'(a), d);
    chk("wr_miso_zero", {24'd0, rx}, 32'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [6:0] a);
    logic [7:0] rx, ext;
    xfer({1'b1, a, 8'($urandom), 16'h0}, 16, 1'b0, rx, ext);
    chk(tag, {24'd0, rx}, {24'd0, m_read(int'(a))});
  endtask

  task automatic chk_pins(input string tag);
    chk({tag, "_out"}, 32'(gpio_out), 32'(m_out));
    chk({tag, "_oe"},  32'(gpio_oe),  32'(m_dir));
    chk({tag, "_irq"}, {31'd0, irq},  {31'd0, |m_ist});
  endtask

  initial begin
    logic [7:0] rx, ext;
    logic [6:0] a;
    m_reset();
    wait_clk(3);
    chk("rst_out", 32'(gpio_out), 32'd0);
    chk("rst_oe", 32'(gpio_oe), 32'd0);
    chk("rst_miso", {30'd0, spi_miso, spi_miso_oe}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b1;
    wait_clk(4);

    // basic writes
    wr(7'h00, 8'hA5);
    wr(7'h01, 8'hFF);
    chk_pins("wr_bank0");
    chk("bank1_out", 32'(gpio_out[15:8]), 32'd0);

    // IN readback of bank 1
    set_gin(16'h3C00);
    rd_chk("rd_in1", 7'h06);

    // change interrupt and W1C
    wr(7'h07, 8'h01);
    wr(7'h05, 8'h00);
    set_gin(gpio_in ^ 16'h0100);
    rd_chk("rd_istat1", 7'h41);
    chk_pins("irq_set");
    wr(7'h41, 8'h01);
    chk_pins("irq_clr");

    // aborted frame after 12 bits, then a normal frame
    xfer({1'b0, 7'h00, 8'hFF, 16'h0}, 12, 1'b0, rx, ext);
    chk_pins("partial");
    wr(7'h00, 8'h5A);
    chk_pins("after_partial");

    // set and clear in the same clk: set wins
    set_gin(gpio_in ^ 16'h0100);
    xfer({1'b0, 7'h41, 8'h01, 16'h0}, 16, 1'b1, rx, ext);
    m_write(7'h41, 8'h01);
    m_pins(gpio_in);
    rd_chk("set_wins", 7'h41);
    chk_pins("set_wins");
    wr(7'h41, 8'hFF);

    // over-long frames
    xfer({1'b0, 7'h00, 8'h3C, 8'hFF, 8'h00}, 24, 1'b0, rx, ext);
    m_write(0, 8'h3C);
    chk_pins("long_wr");
    xfer({1'b1, 7'h00, 8'h00, 8'hFF, 8'h00}, 24, 1'b0, rx, ext);
    chk("long_rd", {24'd0, rx}, {24'd0, m_read(0)});
    chk("long_rd_ext", {24'd0, ext}, 32'd0);

    // randomized frames against the model
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) set_gin(W'($urandom));
      case ($urandom_range(0, 3))
        0: a = 7'($urandom_range(0, 4 * NB - 1));
        1: a = 7'(64 + $urandom_range(0, NB - 1));
        2: a = 7'($urandom);
        default: a = 7'(4 * $urandom_range(0, NB - 1) + 2);
      endcase
      if ($urandom_range(0, 1) == 1) rd_chk("rnd_rd", a);
      else wr(a, 8'($urandom));
      chk_pins("rnd");
    end

    // reset in the middle of a frame
    wr(7'h00, 8'hC3);
    wr(7'h01, 8'h0F);
    spi_ss_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 5; i++) begin
      spi_mosi = 1'b1;
      wait_clk(HALF);
      spi_sclk = 1'b1;
      wait_clk(HALF);
      spi_sclk = 1'b0;
    end
    rst = 1'b0;
    #1;
    chk("midrst_out", 32'(gpio_out), 32'd0);
    chk("midrst_oe", 32'(gpio_oe), 32'd0);
    chk("midrst_miso", {30'd0, spi_miso, spi_miso_oe}, 32'd0);
    chk("midrst_irq", {31'd0, irq}, 32'd0);
    spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    wait_clk(3);
    rst = 1'b1;
    m_reset();
    wait_clk(4);
    rd_chk("rd_unmapped", 7'h7F);
    chk_pins("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
